// File: rtl/vmask_pkg.sv
// vmask_prep shared types: FSM states, beat-index width, beat-count helper.
// Optional vstart masking is enabled by defining VMASK_PREP_VSTART_EN.
package vmask_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ZERO
    } state_t;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_VL_WIDTH   = 16;
    localparam int BEAT_IDX_W     = DEF_VL_WIDTH + 1 - $clog2(DEF_DATA_WIDTH);

    // Number of W-bit beats covering vl elements, W = 2**lw.
    function automatic logic [31:0] ceil_div_w(input logic [31:0] vl,
                                               input int lw);
        return (vl + (32'd1 << lw) - 32'd1) >> lw;
    endfunction

endpackage

// File: rtl/vmask_bound.sv
// vmask_bound: combinational W-bit mask of lanes j with lo <= base+j < hi.
// Index arithmetic is widened so base+j never wraps.
module vmask_bound #(
    parameter int DATA_WIDTH = 64,
    parameter int VL_WIDTH   = 16
) (
    input  logic [VL_WIDTH:0]     base,
    input  logic [VL_WIDTH-1:0]   lo,
    input  logic [VL_WIDTH-1:0]   hi,
    output logic [DATA_WIDTH-1:0] mask
);

    localparam int IW = VL_WIDTH + 2;

    logic [IW-1:0] lo_w;
    logic [IW-1:0] hi_w;

    assign lo_w = {2'b00, lo};
    assign hi_w = {2'b00, hi};

    for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_lane
        logic [IW-1:0] idx;
        assign idx     = {1'b0, base} + IW'(j);
        assign mask[j] = (idx >= lo_w) && (idx < hi_w);
    end

endmodule

// File: rtl/vmask_prep.sv
// vmask_prep: clears tail / masked-off (/ pre-vstart) bits of mask beats.
// Define VMASK_PREP_VSTART_EN to honour in_vstart.
module vmask_prep
    import vmask_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int REQ_ADDR_WIDTH = 32,
    parameter int VL_WIDTH       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_start,
    input  logic [VL_WIDTH-1:0]       in_vl,
    input  logic                      in_vm,
    input  logic [VL_WIDTH-1:0]       in_vstart,
    input  logic [REQ_ADDR_WIDTH-1:0] in_addr,
    input  logic                      in_valid,
    input  logic [DATA_WIDTH-1:0]     in_vs2,
    input  logic [DATA_WIDTH-1:0]     in_v0,
    output logic [DATA_WIDTH-1:0]     out_m0,
    output logic                      out_valid,
    output logic                      out_end,
    output logic [REQ_ADDR_WIDTH-1:0] out_addr,
    output logic                      out_busy
);

    localparam int LW = $clog2(DATA_WIDTH);
    localparam int BW = VL_WIDTH + 1 - LW;

    state_t                    state_q, state_d;
    logic [VL_WIDTH-1:0]       vl_q;
    logic                      vm_q;
    logic [REQ_ADDR_WIDTH-1:0] addr_q;
    logic [BW-1:0]             beat_q, beat_d;
    logic [BW-1:0]             nbeats_q;
    logic                      latch;
    logic                      last;

    logic [VL_WIDTH:0]         base;
    logic [VL_WIDTH-1:0]       lo;
    logic [DATA_WIDTH-1:0]     bound;
    logic [DATA_WIDTH-1:0]     keep;

    logic [DATA_WIDTH-1:0]     m0_d;
    logic                      valid_d;
    logic                      end_d;
    logic [REQ_ADDR_WIDTH-1:0] addr_d;

    // Element base of the current beat is the beat index times W.
    assign base = {beat_q, {LW{1'b0}}};
    assign last = (beat_q + BW'(1)) == nbeats_q;

`ifdef VMASK_PREP_VSTART_EN
    logic [VL_WIDTH-1:0] vstart_q;

    // Hold vstart for the duration of the operation.
    always_ff @(posedge clk) begin
        if (rst)        vstart_q <= '0;
        else if (latch) vstart_q <= in_vstart;
    end

    assign lo = vstart_q;
`else
    logic unused_vstart;
    assign unused_vstart = ^in_vstart;
    assign lo = '0;
`endif

    vmask_bound #(
        .DATA_WIDTH (DATA_WIDTH),
        .VL_WIDTH   (VL_WIDTH)
    ) u_bound (
        .base (base),
        .lo   (lo),
        .hi   (vl_q),
        .mask (bound)
    );

    assign keep     = bound & (vm_q ? {DATA_WIDTH{1'b1}} : in_v0);
    assign out_busy = (state_q != IDLE);

    // Next-state and next-output decode.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        latch   = 1'b0;
        m0_d    = '0;
        valid_d = 1'b0;
        end_d   = 1'b0;
        addr_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (in_start) begin
                    latch   = 1'b1;
                    beat_d  = '0;
                    state_d = (in_vl == '0) ? ZERO : RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    m0_d    = in_vs2 & keep;
                    valid_d = 1'b1;
                    addr_d  = addr_q;
                    beat_d  = beat_q + BW'(1);
                    if (last) begin
                        end_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            ZERO: begin
                valid_d = 1'b1;
                end_d   = 1'b1;
                addr_d  = addr_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, beat counter and operand latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            nbeats_q <= '0;
            vl_q     <= '0;
            vm_q     <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (latch) begin
                vl_q     <= in_vl;
                vm_q     <= in_vm;
                addr_q   <= in_addr;
                nbeats_q <= BW'(ceil_div_w(32'(in_vl), LW));
            end
        end
    end

    // Registered output beat, one cycle after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_m0    <= '0;
            out_valid <= 1'b0;
            out_end   <= 1'b0;
            out_addr  <= '0;
        end else begin
            out_m0    <= m0_d;
            out_valid <= valid_d;
            out_end   <= end_d;
            out_addr  <= addr_d;
        end
    end

endmodule

// File: tb/tb_vmask_prep.sv
// Directed self-checking bench for vmask_prep (W=64).
// Expected values are hand-computed; vstart case depends on VMASK_PREP_VSTART_EN.
module tb_vmask_prep;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_start;
    logic [15:0] in_vl;
    logic        in_vm;
    logic [15:0] in_vstart;
    logic [31:0] in_addr;
    logic        in_valid;
    logic [63:0] in_vs2;
    logic [63:0] in_v0;
    logic [63:0] out_m0;
    logic        out_valid;
    logic        out_end;
    logic [31:0] out_addr;
    logic        out_busy;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ALT  = 64'hAAAA_AAAA_AAAA_AAAA;

    vmask_prep dut (
        .clk       (clk),
        .rst       (rst),
        .in_start  (in_start),
        .in_vl     (in_vl),
        .in_vm     (in_vm),
        .in_vstart (in_vstart),
        .in_addr   (in_addr),
        .in_valid  (in_valid),
        .in_vs2    (in_vs2),
        .in_v0     (in_v0),
        .out_m0    (out_m0),
        .out_valid (out_valid),
        .out_end   (out_end),
        .out_addr  (out_addr),
        .out_busy  (out_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic v, input logic e,
                            input logic [63:0] m, input logic [31:0] a);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".end"},   64'(out_end),   64'(e));
        chk({tag, ".m0"},    out_m0,         m);
        chk({tag, ".addr"},  64'(out_addr),  64'(a));
    endtask

    initial begin
        logic [63:0] exp6;
        rst = 1'b1; in_start = 1'b0; in_vl = '0; in_vm = 1'b1;
        in_vstart = '0; in_addr = '0; in_valid = 1'b0;
        in_vs2 = '0; in_v0 = '0;
        tick(); tick();
        chk_beat("reset", 1'b0, 1'b0, 64'h0, 32'h0);
        chk("reset.busy", 64'(out_busy), 64'd0);
        rst = 1'b0;
        tick();

        // 1: vl=64 unmasked, single full beat
        in_start = 1'b1; in_vl = 16'd64; in_vm = 1'b1; in_addr = 32'h1000;
        tick();
        chk("t1.busy", 64'(out_busy), 64'd1);
        chk("t1.idle_valid", 64'(out_valid), 64'd0);
        in_start = 1'b0; in_addr = 32'h0;
        in_valid = 1'b1; in_vs2 = ONES;
        tick();
        chk_beat("t1.b0", 1'b1, 1'b1, ONES, 32'h1000);
        chk("t1.busy_end", 64'(out_busy), 64'd0);
        in_valid = 1'b0;
        tick();
        chk_beat("t1.gap", 1'b0, 1'b0, 64'h0, 32'h0);

        // 2: vl=70, partial tail; start during busy must be ignored
        in_start = 1'b1; in_vl = 16'd70; in_addr = 32'h2000;
        tick();
        in_vl = 16'd0; in_addr = 32'h9999;
        in_valid = 1'b1; in_vs2 = ONES;
        tick();
        chk_beat("t2.b0", 1'b1, 1'b0, ONES, 32'h2000);
        in_start = 1'b0;
        tick();
        chk_beat("t2.b1", 1'b1, 1'b1, 64'h3F, 32'h2000);
        in_valid = 1'b0;
        tick();

        // 3: vl=64 masked by v0
        in_start = 1'b1; in_vl = 16'd64; in_vm = 1'b0; in_addr = 32'h3000;
        tick();
        in_start = 1'b0;
        in_valid = 1'b1; in_vs2 = ONES; in_v0 = ALT;
        tick();
        chk_beat("t3.b0", 1'b1, 1'b1, ALT, 32'h3000);
        in_valid = 1'b0; in_vm = 1'b1; in_v0 = '0;
        tick();

        // 4: vl=0 framed zero beat, stray beats dropped
        in_start = 1'b1; in_vl = 16'd0; in_addr = 32'h4000;
        tick();
        in_start = 1'b0;
        chk("t4.busy", 64'(out_busy), 64'd1);
        chk("t4.pre_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b1; in_vs2 = ONES;
        tick();
        chk_beat("t4.zero", 1'b1, 1'b1, 64'h0, 32'h4000);
        chk("t4.count", 64'($countones(out_m0)), 64'd0);
        tick();
        chk("t4.drop", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        tick();

        // 5: reset mid-operation, then a fresh vl=8 op
        in_start = 1'b1; in_vl = 16'd200; in_addr = 32'h5000;
        tick();
        in_start = 1'b0;
        in_valid = 1'b1; in_vs2 = ONES;
        tick();
        chk_beat("t5.b0", 1'b1, 1'b0, ONES, 32'h5000);
        rst = 1'b1;
        tick();
        chk_beat("t5.rst", 1'b0, 1'b0, 64'h0, 32'h0);
        chk("t5.rst_busy", 64'(out_busy), 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("t5.no_end", 64'(out_end), 64'd0);
        in_start = 1'b1; in_vl = 16'd8; in_addr = 32'h5100;
        tick();
        in_start = 1'b0;
        in_valid = 1'b1; in_vs2 = ONES;
        tick();
        chk_beat("t5.vl8", 1'b1, 1'b1, 64'hFF, 32'h5100);
        in_valid = 1'b0;
        tick();

        // 6: vstart=4, vl=8; back-to-back start on the end cycle
`ifdef VMASK_PREP_VSTART_EN
        exp6 = 64'hF0;
`else
        exp6 = 64'hFF;
`endif
        in_start = 1'b1; in_vl = 16'd8; in_vstart = 16'd4; in_addr = 32'h6000;
        tick();
        in_start = 1'b0;
        in_valid = 1'b1; in_vs2 = ONES;
        tick();
        chk_beat("t6.b0", 1'b1, 1'b1, exp6, 32'h6000);
        in_valid = 1'b0;
        in_start = 1'b1; in_vl = 16'd64; in_vstart = 16'd0; in_addr = 32'h6100;
        tick();
        chk("t6.b2b_busy", 64'(out_busy), 64'd1);
        in_start = 1'b0;
        in_valid = 1'b1; in_vs2 = ALT;
        tick();
        chk_beat("t6.b2b", 1'b1, 1'b1, ALT, 32'h6100);
        in_valid = 1'b0;
        tick();
        chk("t6.idle", 64'(out_busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
